// File: rtl/wb_interconnect_pkg.sv
// Shared types for the Wishbone interconnect: arbiter FSM states and an
// index-width helper used to size grant ids and round-robin pointers.
package wb_interconnect_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2
   } arb_state_e;

   // Width of a binary index into an n-entry vector, never below one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wb_rr_find_first.sv
// Combinational wrap-around search: first set bit of vec at or above ptr,
// wrapping from N-1 back to 0.
module wb_rr_find_first
   import wb_interconnect_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]           vec,
   input  logic [id_width(N)-1:0] ptr,
   output logic                   found,
   output logic [id_width(N)-1:0] index
);

   localparam int unsigned W = id_width(N);

   logic [W:0]   sum;
   logic [W-1:0] pos;

   always_comb begin
      found = 1'b0;
      index = '0;
      sum   = '0;
      pos   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         // One spare bit holds ptr+i before the modulo-N fold.
         sum = {1'b0, ptr} + (W+1)'(i);
         if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
         end
         pos = sum[W-1:0];
         if (!found && vec[pos]) begin
            found = 1'b1;
            index = pos;
         end
      end
   end

endmodule

// File: rtl/wb_arb_rr_lock.sv
// Round-robin Wishbone arbiter with cycle lock and optional watchdog.
// Watchdog (counter, FLUSH state, timeout_err) enabled by WB_ARB_RR_LOCK_TIMEOUT_EN.
module wb_arb_rr_lock
   import wb_interconnect_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req,
   input  logic                       ack_i,
   input  logic                       err_i,
   output logic [N_REQ-1:0]           gnt,
   output logic [id_width(N_REQ)-1:0] gnt_id,
   output logic                       active,
   output logic                       timeout_err
);

   localparam int unsigned ID_W = id_width(N_REQ);

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic              timeout_err_q, timeout_err_d;

   logic              find_found;
   logic [ID_W-1:0]   find_idx;
   logic              owner_req;
   logic [ID_W-1:0]   next_ptr;
   logic              timeout_hit;

   wb_rr_find_first #(
      .N (N_REQ)
   ) u_find (
      .vec   (req),
      .ptr   (ptr_q),
      .found (find_found),
      .index (find_idx)
   );

   assign owner_req = req[gnt_id_q];
   assign next_ptr  = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

`ifdef WB_ARB_RR_LOCK_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // ack/err in the limit cycle suppresses the timeout.
   assign timeout_hit = (state_q == BUSY) && !ack_i && !err_i &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY && state_d == BUSY && !ack_i && !err_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_wd;

   assign timeout_hit = 1'b0;
   assign unused_wd   = ack_i | err_i | (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         gnt_q         <= '0;
         gnt_id_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         gnt_q         <= gnt_d;
         gnt_id_q      <= gnt_id_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (find_found) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Owner release takes priority; a coincident timeout still pulses.
            if (!owner_req) begin
               state_d = IDLE;
               ptr_d   = next_ptr;
            end else if (timeout_hit) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (!owner_req) begin
               state_d = IDLE;
               ptr_d   = next_ptr;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      gnt_d         = gnt_q;
      gnt_id_d      = gnt_id_q;
      timeout_err_d = timeout_hit;
      unique case (state_q)
         IDLE: begin
            gnt_d    = '0;
            gnt_id_d = '0;
            if (find_found) begin
               gnt_d[find_idx] = 1'b1;
               gnt_id_d        = find_idx;
            end
         end
         BUSY, FLUSH: begin
            if (!owner_req) begin
               gnt_d    = '0;
               gnt_id_d = '0;
            end
         end
         default: begin
            gnt_d    = '0;
            gnt_id_d = '0;
         end
      endcase
   end

   assign gnt         = gnt_q;
   assign gnt_id      = gnt_id_q;
   assign active      = |gnt_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_wb_arb_rr_lock.sv
// Self-checking bench for wb_arb_rr_lock (N_REQ=4, TIMEOUT_CYCLES=16):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_arb_rr_lock;

   localparam int N  = 4;
   localparam int TO = 16;
`ifdef WB_ARB_RR_LOCK_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       ack_i;
   logic       err_i;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       active;
   logic       timeout_err;

   int total = 0;
   int bad   = 0;

   // Behavioural model: owner index (-1 idle), round-robin pointer,
   // cycles since grant/ack, whether the watchdog already fired.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_wd    = 0;
   bit m_flush = 1'b0;
   bit m_to    = 1'b0;

   wb_arb_rr_lock #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .ack_i       (ack_i),
      .err_i       (err_i),
      .gnt         (gnt),
      .gnt_id      (gnt_id),
      .active      (active),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   task automatic model_step();
      if (reset) begin
         m_owner = -1;
         m_ptr   = 0;
         m_wd    = 0;
         m_flush = 1'b0;
         m_to    = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         m_wd = 0;
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (m_owner < 0 && req[c]) m_owner = c;
         end
      end else begin
         m_to = TO_EN && !m_flush && !ack_i && !err_i && (m_wd == TO - 1);
         if (ack_i || err_i) m_wd = 0;
         else m_wd++;
         if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_flush = 1'b0;
         end else if (m_to) begin
            m_flush = 1'b1;
         end
      end
   endtask

   function automatic logic [3:0] model_gnt();
      logic [3:0] g;
      g = 4'b0000;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'b0000; ack_i = 1'b0; err_i = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
   endtask

   task automatic test_idle_request();
      cycle();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL idle_stays: got %b want 0000", gnt); end
      req = 4'b0100;
      cycle();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL idle_gnt: got %b want 0100", gnt); end
      total++; if (gnt_id !== 2'd2) begin bad++; $display("FAIL idle_gnt_id: got %0d want 2", gnt_id); end
      total++; if (active !== 1'b1) begin bad++; $display("FAIL idle_active: got %b want 1", active); end
      req = 4'b0000;
      cycle();
      total++; if (gnt !== 4'b0000 || active !== 1'b0) begin bad++; $display("FAIL idle_release: got gnt=%b active=%b want 0000/0", gnt, active); end
      req = 4'b1111;
      cycle();
      total++; if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin bad++; $display("FAIL idle_ptr3: got gnt=%b id=%0d want 1000/3", gnt, gnt_id); end
      req = 4'b0000;
      cycle();
   endtask

   task automatic test_fairness();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [3:0] r;
      req = 4'b1111;
      cycle();
      for (int k = 0; k < 5; k++) begin
         total++; if (gnt_id !== 2'(order[k])) begin bad++; $display("FAIL fair_order%0d: got %0d want %0d", k, gnt_id, order[k]); end
         cycle();
         cycle();
         total++; if (gnt_id !== 2'(order[k]) || active !== 1'b1) begin bad++; $display("FAIL fair_hold%0d: got id=%0d active=%b want %0d/1", k, gnt_id, active, order[k]); end
         r = 4'b1111;
         r[order[k]] = 1'b0;
         req = r;
         cycle();
         total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL fair_gap%0d: got %b want 0000", k, gnt); end
         req = (k == 4) ? 4'b0000 : 4'b1111;
         cycle();
      end
   endtask

   task automatic test_lock();
      req = 4'b0010;
      cycle();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lock_gnt: got %b want 0010", gnt); end
      req = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         cycle();
         total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lock_hold%0d: got %b want 0010", i, gnt); end
      end
      req = 4'b1000;
      cycle();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL lock_idle: got %b want 0000", gnt); end
      cycle();
      total++; if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin bad++; $display("FAIL lock_next: got gnt=%b id=%0d want 1000/3", gnt, gnt_id); end
      req = 4'b0000;
      cycle();
   endtask

`ifdef WB_ARB_RR_LOCK_TIMEOUT_EN
   task automatic test_timeout();
      int pulses;
      req = 4'b0001; ack_i = 1'b0;
      cycle();
      pulses = 0;
      for (int i = 1; i < TO; i++) begin
         cycle();
         if (timeout_err) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL to_early: got %0d pulses want 0", pulses); end
      cycle();
      total++; if (timeout_err !== 1'b1 || gnt !== 4'b0001) begin bad++; $display("FAIL to_pulse: got to=%b gnt=%b want 1/0001", timeout_err, gnt); end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (timeout_err || gnt !== 4'b0001) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL to_flush: got %0d bad cycles want 0", pulses); end
      req = 4'b0000;
      cycle();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL to_release: got %b want 0000", gnt); end
      // ack in the limit cycle beats the watchdog
      req = 4'b0001;
      cycle();
      for (int i = 1; i < TO; i++) cycle();
      ack_i = 1'b1;
      cycle();
      ack_i = 1'b0;
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_ack_wins: got %b want 0", timeout_err); end
      for (int i = 0; i < 5; i++) cycle();
      total++; if (timeout_err !== 1'b0 || gnt !== 4'b0001) begin bad++; $display("FAIL to_after_ack: got to=%b gnt=%b want 0/0001", timeout_err, gnt); end
      req = 4'b0000;
      cycle();
      // owner drops in the limit cycle: pulse and straight to idle
      req = 4'b0001;
      cycle();
      for (int i = 1; i < TO; i++) cycle();
      req = 4'b0000;
      cycle();
      total++; if (timeout_err !== 1'b1 || gnt !== 4'b0000) begin bad++; $display("FAIL to_drop: got to=%b gnt=%b want 1/0000", timeout_err, gnt); end
      cycle();
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_drop_once: got %b want 0", timeout_err); end
   endtask
`else
   task automatic test_no_timeout();
      int bad_cycles;
      req = 4'b0001; ack_i = 1'b0; err_i = 1'b0;
      cycle();
      bad_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (timeout_err !== 1'b0 || gnt !== 4'b0001) bad_cycles++;
      end
      total++; if (bad_cycles != 0) begin bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad_cycles); end
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL stall_gnt: got %b want 0001", gnt); end
      req = 4'b0000;
      cycle();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL stall_release: got %b want 0000", gnt); end
   endtask
`endif

   task automatic test_reset_mid_busy();
      req = 4'b0100;
      cycle();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rst_busy_gnt: got %b want 0100", gnt); end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      total++; if (gnt !== 4'b0000 || gnt_id !== 2'd0 || active !== 1'b0 || timeout_err !== 1'b0) begin
         bad++; $display("FAIL rst_busy_clear: got gnt=%b id=%0d act=%b to=%b want all 0", gnt, gnt_id, active, timeout_err);
      end
      req = 4'b0001;
      cycle();
      total++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin bad++; $display("FAIL rst_regrant: got gnt=%b id=%0d want 0001/0", gnt, gnt_id); end
      req = 4'b0000;
      cycle();
   endtask

   task automatic test_random();
      logic [3:0] r;
      int errs;
      r = 4'b0000;
      errs = 0;
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 6) == 0) r[b] = ~r[b];
         end
         req   = r;
         ack_i = ($urandom_range(0, 24) == 0);
         err_i = ($urandom_range(0, 49) == 0);
         reset = ($urandom_range(0, 199) == 0);
         cycle();
         total++; if (gnt !== model_gnt()) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_gnt@%0d: got %b want %b", n, gnt, model_gnt()); end
         total++; if (gnt_id !== 2'((m_owner < 0) ? 0 : m_owner)) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_id@%0d: got %0d want %0d", n, gnt_id, (m_owner < 0) ? 0 : m_owner); end
         total++; if (active !== (m_owner >= 0)) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_active@%0d: got %b want %b", n, active, m_owner >= 0); end
         total++; if (timeout_err !== m_to) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_to@%0d: got %b want %b", n, timeout_err, m_to); end
      end
      reset = 1'b0; req = 4'b0000; ack_i = 1'b0; err_i = 1'b0;
      cycle();
      cycle();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rnd_drain: got %b want 0000", gnt); end
   endtask

   initial begin
      test_reset();
      test_idle_request();
      test_fairness();
      test_lock();
`ifdef WB_ARB_RR_LOCK_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_busy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_arb_rr_lock.md
WB_ARB_RR_LOCK -- requirements
Module: wb_arb_rr_lock

Interface
REQ-001 Parameter N_REQ, default 4: number of requesting initiators, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: cycles without ack/err before the watchdog fires, 2..65535.
REQ-003 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, N_REQ: per-initiator request, the initiator's cyc&&stb.
REQ-006 Port ack_i, input, 1: ack from the shared target.
REQ-007 Port err_i, input, 1: err from the shared target.
REQ-008 Port gnt, output, N_REQ: registered one-hot grant, all-zero when idle.
REQ-009 Port gnt_id, output, $clog2(N_REQ): binary index of the owner, 0 when idle.
REQ-010 Port active, output, 1: high whenever gnt is non-zero.
REQ-011 Port timeout_err, output, 1: one-cycle watchdog error pulse toward the owner.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and FLUSH.
REQ-013 In IDLE with req non-zero, the arbiter SHALL select the first set req bit, searching upward from ptr with wrap, and enter BUSY with gnt set at the next edge (1-cycle arbitration latency).
REQ-014 In IDLE with req zero, the arbiter SHALL stay in IDLE with gnt=0.
REQ-015 In BUSY, gnt SHALL hold while req[gnt_id]=1 (cycle lock), regardless of any other requests.
REQ-016 In BUSY with req[gnt_id]=0, the arbiter SHALL go to IDLE, clear gnt at that edge, and set ptr=(gnt_id+1) mod N_REQ.
REQ-017 Re-arbitration SHALL only occur from IDLE, so there is at least one idle cycle between different owners.
REQ-018 ptr SHALL wrap from N_REQ-1 to 0; a lone requester SHALL be re-granted repeatedly.
REQ-019 The watchdog counter SHALL clear on entry to BUSY and on any cycle with ack_i or err_i high, and otherwise increment in BUSY.
REQ-020 When the counter reaches TIMEOUT_CYCLES-1 without ack_i/err_i, the block SHALL pulse timeout_err for one cycle at the next edge and enter FLUSH.
REQ-021 In FLUSH, gnt SHALL hold and timeout_err SHALL be 0.
REQ-022 In FLUSH, the block SHALL go to IDLE when req[gnt_id]=0, updating ptr as in REQ-016.
REQ-023 If ack_i or err_i arrives in the same cycle the counter reaches its limit, the ack/err SHALL win and no timeout is raised.
REQ-024 If req[gnt_id] drops in the same cycle as the timeout, the block SHALL go directly to IDLE and still emit the timeout_err pulse.
REQ-025 The counter SHALL be sized to hold TIMEOUT_CYCLES and SHALL never wrap.

Reset
REQ-026 On reset: state=IDLE, gnt=0, gnt_id=0, active=0, timeout_err=0, ptr=0, counter=0.
REQ-027 Reset asserted mid-transaction SHALL drop gnt at the next edge; no timeout_err SHALL be issued while reset is high.

Configuration
REQ-028 The macro WB_ARB_RR_LOCK_TIMEOUT_EN SHALL control the watchdog.
REQ-029 With WB_ARB_RR_LOCK_TIMEOUT_EN defined: counter, FLUSH state and timeout_err behave per REQ-019..REQ-025.
REQ-030 Without WB_ARB_RR_LOCK_TIMEOUT_EN: no counter is synthesized, FLUSH is unreachable, timeout_err is tied 0, and BUSY exits only per REQ-016.

Structure
REQ-031 The FSM state enum (IDLE, BUSY, FLUSH) and a clog2-based width helper constant SHALL live in the shared package wb_interconnect_pkg.
REQ-032 The wrap-around first-set search SHALL be a combinational sub-module wb_rr_find_first (inputs vector and ptr; outputs found and index).
REQ-033 This block SHALL be instantiable per target in the NxN interconnect in place of the existing arbiter, with req driven by the per-target request vector.

Verification (N_REQ=4, TIMEOUT_CYCLES=16)
REQ-034 Idle request: req=4'b0100 from IDLE -> gnt=4'b0100 and gnt_id=2 one cycle later; req cleared -> gnt=0 the next cycle; ptr=3.
REQ-035 Fairness: req=4'b1111 held, each owner dropping req for one cycle after 3 cycles -> grant order 0,1,2,3,0.
REQ-036 Lock: owner 1 busy and req[3] asserted -> gnt stays 4'b0010 until req[1]=0; then IDLE, then gnt=4'b1000.
REQ-037 Timeout: owner 0, no ack for 16 cycles -> one timeout_err pulse, FLUSH, gnt held until req[0]=0; ack on cycle 15 -> no pulse.
REQ-038 Reset mid-BUSY: reset for 1 cycle -> all outputs 0 next edge; after release, req=4'b0001 -> gnt=4'b0001 (ptr=0).
REQ-039 Macro undefined: owner stalled 100 cycles -> timeout_err stays 0 and gnt is held.
